// File: rtl/matrix_vector_mac_seq_if.sv
// Operand/result bundle for the sequential matrix-by-vector MAC.
// The master side stages operands and consumes results; the slave side
// is the MAC engine itself.
interface matrix_vector_mac_seq_if #(
    parameter int M     = 4,
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int ACC_W = 2*DW + $clog2(N)
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DW*N*M-1:0]    matrix_inp;
    logic [DW*N-1:0]      vector_inp;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_W*M-1:0]   outp;
    logic                 busy;

    modport master (
        output in_valid,
        output matrix_inp,
        output vector_inp,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  outp,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  matrix_inp,
        input  vector_inp,
        input  out_ready,
        output in_ready,
        output out_valid,
        output outp,
        output busy
    );
endinterface

// File: rtl/matrix_vector_mac_seq.sv
// Sequential M x N matrix-by-vector multiplier.
// One transaction = one registered matrix and vector. M parallel MAC lanes
// walk the columns one per cycle, then the result is held until the
// consumer takes it. Operands may be unsigned or two's complement.
module matrix_vector_mac_seq #(
    parameter int M      = 4,
    parameter int N      = 4,
    parameter int DW     = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    matrix_vector_mac_seq_if.slave  bus
);

    // Accumulator width is sized so that N full-scale products can never overflow.
    localparam int ACC_W = 2*DW + $clog2(N);
    localparam int KW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N-1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t              state_q;
    logic                inReady_q;
    logic                outValid_q;
    logic                busy_q;
    logic [KW-1:0]       k_q;
    logic [DW*N*M-1:0]   mat_q;
    logic [DW*N-1:0]     vec_q;
    logic [ACC_W-1:0]    acc_q [M];
    logic [ACC_W-1:0]    acc_d [M];
    logic [ACC_W*M-1:0]  outp_q;
    logic [ACC_W*M-1:0]  sums_d;
    logic [DW-1:0]       colVec;
    logic [ACC_W-1:0]    colVecExt;

    // Pick the vector element for the current column and widen it to the
    // accumulator width, sign- or zero-extending according to SIGNED.
    always_comb begin
        colVec = vec_q[int'(k_q)*DW +: DW];
        if (SIGNED) begin
            colVecExt = {{(ACC_W-DW){colVec[DW-1]}}, colVec};
        end else begin
            colVecExt = {{(ACC_W-DW){1'b0}}, colVec};
        end
    end

    // One MAC lane per matrix row. Both operands are extended to ACC_W
    // before multiplying, so the truncated ACC_W-bit product is the exact
    // extended 2*DW product in either arithmetic mode.
    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_lane
            logic [DW-1:0]    aElem;
            logic [ACC_W-1:0] aElemExt;
            logic [ACC_W-1:0] prodExt;

            assign aElem = mat_q[gi*DW*N + int'(k_q)*DW +: DW];

            if (SIGNED) begin : g_signed
                assign aElemExt = {{(ACC_W-DW){aElem[DW-1]}}, aElem};
            end else begin : g_unsigned
                assign aElemExt = {{(ACC_W-DW){1'b0}}, aElem};
            end

            assign prodExt = aElemExt * colVecExt;
            assign acc_d[gi] = acc_q[gi] + prodExt;
            assign sums_d[gi*ACC_W +: ACC_W] = acc_d[gi];
        end
    endgenerate

    // Transaction sequencer: accept operands in IDLE, accumulate one column
    // per cycle in BUSY, hold the result in DONE until it is taken. The
    // handshake flags are registered alongside the state so no input can
    // reach an output combinationally. Reset aborts any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
            k_q        <= '0;
            mat_q      <= '0;
            vec_q      <= '0;
            outp_q     <= '0;
            for (int i = 0; i < M; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        mat_q     <= bus.matrix_inp;
                        vec_q     <= bus.vector_inp;
                        k_q       <= '0;
                        for (int i = 0; i < M; i++) begin
                            acc_q[i] <= '0;
                        end
                        state_q   <= BUSY;
                        inReady_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                BUSY: begin
                    for (int i = 0; i < M; i++) begin
                        acc_q[i] <= acc_d[i];
                    end
                    if (k_q == K_LAST) begin
                        outp_q     <= sums_d;
                        k_q        <= '0;
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        outValid_q <= 1'b1;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q    <= IDLE;
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    inReady_q  <= 1'b1;
                    outValid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = inReady_q;
    assign bus.out_valid = outValid_q;
    assign bus.busy      = busy_q;
    assign bus.outp      = outp_q;

endmodule

// File: tb/tb_matrix_vector_mac_seq.sv
// Self-checking bench for matrix_vector_mac_seq.
// Small 2x2 units (unsigned and signed) run a hand-computed vector table,
// a 3x1 unit covers the single-column case, and two default-size units
// (unsigned and signed, driven identically) run directed corner cases and
// random back-to-back traffic against an arithmetic reference model.
module tb_matrix_vector_mac_seq;

    localparam int SM = 2, SN = 2, SDW = 2, SACC = 2*SDW + $clog2(SN);
    localparam int BM = 4, BN = 4, BDW = 8, BACC = 2*BDW + $clog2(BN);
    localparam int TM = 3, TN = 1, TDW = 8, TACC = 2*TDW + $clog2(TN);

    logic clk;
    logic rst;
    int   nChecks = 0;
    int   nFails  = 0;
    int   cyc     = 0;

    logic                     smValid, smOutReady;
    logic [SDW*SN*SM-1:0]     smMat;
    logic [SDW*SN-1:0]        smVec;
    logic                     bgValid, bgOutReady;
    logic [BDW*BN*BM-1:0]     bgMat;
    logic [BDW*BN-1:0]        bgVec;
    logic                     tnValid, tnOutReady;
    logic [TDW*TN*TM-1:0]     tnMat;
    logic [TDW*TN-1:0]        tnVec;

    matrix_vector_mac_seq_if #(.M(SM), .N(SN), .DW(SDW)) ifA ();
    matrix_vector_mac_seq_if #(.M(SM), .N(SN), .DW(SDW)) ifB ();
    matrix_vector_mac_seq_if #(.M(BM), .N(BN), .DW(BDW)) ifC ();
    matrix_vector_mac_seq_if #(.M(BM), .N(BN), .DW(BDW)) ifE ();
    matrix_vector_mac_seq_if #(.M(TM), .N(TN), .DW(TDW)) ifD ();

    assign ifA.in_valid = smValid;   assign ifB.in_valid = smValid;
    assign ifA.matrix_inp = smMat;   assign ifB.matrix_inp = smMat;
    assign ifA.vector_inp = smVec;   assign ifB.vector_inp = smVec;
    assign ifA.out_ready = smOutReady; assign ifB.out_ready = smOutReady;
    assign ifC.in_valid = bgValid;   assign ifE.in_valid = bgValid;
    assign ifC.matrix_inp = bgMat;   assign ifE.matrix_inp = bgMat;
    assign ifC.vector_inp = bgVec;   assign ifE.vector_inp = bgVec;
    assign ifC.out_ready = bgOutReady; assign ifE.out_ready = bgOutReady;
    assign ifD.in_valid = tnValid;
    assign ifD.matrix_inp = tnMat;
    assign ifD.vector_inp = tnVec;
    assign ifD.out_ready = tnOutReady;

    matrix_vector_mac_seq #(.M(SM), .N(SN), .DW(SDW), .SIGNED(1'b0)) dutA (.clk(clk), .rst(rst), .bus(ifA));
    matrix_vector_mac_seq #(.M(SM), .N(SN), .DW(SDW), .SIGNED(1'b1)) dutB (.clk(clk), .rst(rst), .bus(ifB));
    matrix_vector_mac_seq #(.M(BM), .N(BN), .DW(BDW), .SIGNED(1'b0)) dutC (.clk(clk), .rst(rst), .bus(ifC));
    matrix_vector_mac_seq #(.M(BM), .N(BN), .DW(BDW), .SIGNED(1'b1)) dutE (.clk(clk), .rst(rst), .bus(ifE));
    matrix_vector_mac_seq #(.M(TM), .N(TN), .DW(TDW), .SIGNED(1'b0)) dutD (.clk(clk), .rst(rst), .bus(ifD));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges despite the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [SDW*SN*SM-1:0] mat;
        logic [SDW*SN-1:0]    vec;
        logic [SACC*SM-1:0]   expU;
        logic [SACC*SM-1:0]   expS;
    } smallVec_t;

    smallVec_t tbl [6];

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
        end
    endtask

    // Exact dot products computed with plain integer arithmetic.
    function automatic logic [BACC*BM-1:0] modelBig(input logic [BDW*BN*BM-1:0] mat,
                                                    input logic [BDW*BN-1:0] vec,
                                                    input bit sgn);
        logic [BACC*BM-1:0]     r;
        logic [63:0]            sum;
        longint                 a, v;
        logic signed [BDW-1:0]  ta, tv;
        r = '0;
        for (int i = 0; i < BM; i++) begin
            sum = '0;
            for (int k = 0; k < BN; k++) begin
                ta = mat[(i*BN + k)*BDW +: BDW];
                tv = vec[k*BDW +: BDW];
                if (sgn) begin
                    a = ta;
                    v = tv;
                end else begin
                    a = longint'(mat[(i*BN + k)*BDW +: BDW]);
                    v = longint'(vec[k*BDW +: BDW]);
                end
                sum = sum + 64'(a * v);
            end
            r[i*BACC +: BACC] = sum[BACC-1:0];
        end
        return r;
    endfunction

    // Scoreboard for the default-size pair: record expected results at each
    // accept, compare at each output handshake, forget everything on reset.
    logic [BACC*BM-1:0] expUq [$];
    logic [BACC*BM-1:0] expSq [$];
    int acceptCyc [$];
    int acceptCount = 0;
    int lastHsCyc   = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            expUq.delete();
            expSq.delete();
        end else begin
            if (ifC.in_valid && ifC.in_ready) begin
                expUq.push_back(modelBig(bgMat, bgVec, 1'b0));
                expSq.push_back(modelBig(bgMat, bgVec, 1'b1));
                acceptCyc.push_back(cyc);
                acceptCount++;
            end
            if (ifC.out_valid && ifC.out_ready) begin
                lastHsCyc = cyc;
                checkOutput("big result pending", 128'(expUq.size() > 0), 128'd1);
                checkOutput("signed unit valid at handshake", 128'(ifE.out_valid), 128'd1);
                if (expUq.size() > 0) begin
                    checkOutput("big unsigned result", 128'(ifC.outp), 128'(expUq.pop_front()));
                    checkOutput("big signed result", 128'(ifE.outp), 128'(expSq.pop_front()));
                end
            end
        end
    end

    task automatic applyStimulus(input logic [SDW*SN*SM-1:0] mat, input logic [SDW*SN-1:0] vec);
        smMat   = mat;
        smVec   = vec;
        smValid = 1'b1;
        @(posedge clk); #1;
        smValid = 1'b0;
        smMat   = SDW*SN*SM'($urandom);
        smVec   = SDW*SN'($urandom);
    endtask

    task automatic applyBig(input logic [BDW*BN*BM-1:0] mat, input logic [BDW*BN-1:0] vec);
        bgMat   = mat;
        bgVec   = vec;
        bgValid = 1'b1;
        @(posedge clk); #1;
        bgValid = 1'b0;
        bgMat   = {$urandom, $urandom, $urandom, $urandom};
        bgVec   = $urandom;
    endtask

    task automatic waitBigValid(output int cnt);
        cnt = 0;
        while (!ifC.out_valid && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
    endtask

    logic [BDW*BN*BM-1:0] m1, m2;
    logic [BDW*BN-1:0]    v1, v2;
    logic [BACC*BM-1:0]   expHeld;
    int cnt;
    int base;
    int budget;

    initial begin
        rst = 1'b1;
        smValid = 1'b0; smOutReady = 1'b1; smMat = '0; smVec = '0;
        bgValid = 1'b0; bgOutReady = 1'b1; bgMat = '0; bgVec = '0;
        tnValid = 1'b0; tnOutReady = 1'b1; tnMat = '0; tnVec = '0;

        tbl[0] = '{8'b1111_1001, 4'b1011, {5'd15, 5'd7}, {5'd3,  5'd3}};
        tbl[1] = '{8'b1101_1010, 4'b1010, {5'd8,  5'd8}, {5'd0,  5'd8}};
        tbl[2] = '{8'b1010_1010, 4'b1010, {5'd8,  5'd8}, {5'd8,  5'd8}};
        tbl[3] = '{8'b0101_0101, 4'b1010, {5'd4,  5'd4}, {5'd28, 5'd28}};
        tbl[4] = '{8'b0000_0000, 4'b0000, {5'd0,  5'd0}, {5'd0,  5'd0}};
        tbl[5] = '{8'b1111_1111, 4'b1111, {5'd18, 5'd18}, {5'd2, 5'd2}};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Post-reset state on every unit.
        checkOutput("A reset in_ready", 128'(ifA.in_ready), 128'd1);
        checkOutput("A reset out_valid", 128'(ifA.out_valid), 128'd0);
        checkOutput("A reset busy", 128'(ifA.busy), 128'd0);
        checkOutput("A reset outp", 128'(ifA.outp), 128'd0);
        checkOutput("B reset in_ready", 128'(ifB.in_ready), 128'd1);
        checkOutput("C reset in_ready", 128'(ifC.in_ready), 128'd1);
        checkOutput("C reset out_valid", 128'(ifC.out_valid), 128'd0);
        checkOutput("C reset outp", 128'(ifC.outp), 128'd0);
        checkOutput("D reset in_ready", 128'(ifD.in_ready), 128'd1);
        checkOutput("E reset busy", 128'(ifE.busy), 128'd0);

        // 2x2 table, unsigned and signed units in lockstep.
        for (int e = 0; e < 6; e++) begin
            checkOutput($sformatf("small[%0d] in_ready before", e), 128'(ifA.in_ready), 128'd1);
            applyStimulus(tbl[e].mat, tbl[e].vec);
            checkOutput($sformatf("small[%0d] busy", e), 128'(ifA.busy), 128'd1);
            checkOutput($sformatf("small[%0d] in_ready busy", e), 128'(ifB.in_ready), 128'd0);
            cnt = 0;
            while (!ifA.out_valid && cnt < 20) begin
                @(posedge clk); #1;
                cnt++;
            end
            checkOutput($sformatf("small[%0d] latency", e), 128'(cnt), 128'(SN));
            checkOutput($sformatf("small[%0d] unsigned outp", e), 128'(ifA.outp), 128'(tbl[e].expU));
            checkOutput($sformatf("small[%0d] signed outp", e), 128'(ifB.outp), 128'(tbl[e].expS));
            checkOutput($sformatf("small[%0d] signed valid", e), 128'(ifB.out_valid), 128'd1);
            @(posedge clk); #1;
            checkOutput($sformatf("small[%0d] valid drop", e), 128'(ifA.out_valid), 128'd0);
            checkOutput($sformatf("small[%0d] in_ready back", e), 128'(ifA.in_ready), 128'd1);
            checkOutput($sformatf("small[%0d] outp kept", e), 128'(ifA.outp), 128'(tbl[e].expU));
        end

        // Single-column unit: one BUSY cycle.
        tnMat = {8'd255, 8'd200, 8'd10};
        tnVec = 8'd3;
        tnValid = 1'b1;
        @(posedge clk); #1;
        tnValid = 1'b0;
        checkOutput("tiny busy", 128'(ifD.busy), 128'd1);
        cnt = 0;
        while (!ifD.out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        checkOutput("tiny latency", 128'(cnt), 128'(TN));
        checkOutput("tiny outp", 128'(ifD.outp), 128'({16'd765, 16'd600, 16'd30}));
        @(posedge clk); #1;
        tnVec = 8'd255;
        tnValid = 1'b1;
        @(posedge clk); #1;
        tnValid = 1'b0;
        @(posedge clk); #1;
        checkOutput("tiny outp 2", 128'(ifD.outp), 128'({16'd65025, 16'd51000, 16'd2550}));
        @(posedge clk); #1;

        // Full-scale operands.
        bgOutReady = 1'b1;
        checkOutput("big in_ready before", 128'(ifC.in_ready), 128'd1);
        applyBig('1, '1);
        checkOutput("big busy", 128'(ifC.busy), 128'd1);
        waitBigValid(cnt);
        checkOutput("big latency", 128'(cnt), 128'(BN));
        checkOutput("big all-255 sums", 128'(ifC.outp), 128'({4{18'd260100}}));
        checkOutput("big all-minus-one sums", 128'(ifE.outp), 128'({4{18'd4}}));
        @(posedge clk); #1;

        // Backpressure with competing input traffic.
        bgOutReady = 1'b0;
        m1 = {$urandom, $urandom, $urandom, $urandom}; v1 = $urandom;
        m2 = {$urandom, $urandom, $urandom, $urandom}; v2 = $urandom;
        expHeld = modelBig(m1, v1, 1'b0);
        applyBig(m1, v1);
        waitBigValid(cnt);
        checkOutput("bp latency", 128'(cnt), 128'(BN));
        checkOutput("bp outp", 128'(ifC.outp), 128'(expHeld));
        bgMat = m2; bgVec = v2; bgValid = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("bp[%0d] out_valid held", s), 128'(ifC.out_valid), 128'd1);
            checkOutput($sformatf("bp[%0d] in_ready low", s), 128'(ifC.in_ready), 128'd0);
            checkOutput($sformatf("bp[%0d] outp held", s), 128'(ifC.outp), 128'(expHeld));
        end
        bgOutReady = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp valid drop", 128'(ifC.out_valid), 128'd0);
        checkOutput("bp in_ready back", 128'(ifC.in_ready), 128'd1);
        @(posedge clk); #1;
        bgValid = 1'b0;
        checkOutput("bp next accepted", 128'(ifC.busy), 128'd1);
        checkOutput("bp accept spacing", 128'(acceptCyc[$] - lastHsCyc), 128'd1);
        waitBigValid(cnt);
        checkOutput("bp second outp", 128'(ifC.outp), 128'(modelBig(m2, v2, 1'b0)));
        @(posedge clk); #1;

        // Reset in the middle of accumulation.
        applyBig({$urandom, $urandom, $urandom, $urandom}, $urandom);
        @(posedge clk); #1;
        checkOutput("abort busy before reset", 128'(ifC.busy), 128'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abort in_ready", 128'(ifC.in_ready), 128'd1);
        checkOutput("abort out_valid", 128'(ifC.out_valid), 128'd0);
        checkOutput("abort busy", 128'(ifC.busy), 128'd0);
        checkOutput("abort outp", 128'(ifC.outp), 128'd0);
        checkOutput("abort signed outp", 128'(ifE.outp), 128'd0);
        for (int s = 0; s < BN + 3; s++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("abort[%0d] no valid", s), 128'(ifC.out_valid | ifE.out_valid), 128'd0);
        end

        // Random back-to-back traffic with both handshakes held high.
        acceptCyc.delete();
        base = acceptCount;
        bgOutReady = 1'b1;
        bgValid = 1'b1;
        budget = 0;
        while ((acceptCount - base) < 20 && budget < 20*(BN+2) + 50) begin
            bgMat = {$urandom, $urandom, $urandom, $urandom};
            bgVec = $urandom;
            @(posedge clk); #1;
            budget++;
        end
        bgValid = 1'b0;
        checkOutput("b2b accept count", 128'(acceptCount - base), 128'd20);
        for (int j = 1; j < acceptCyc.size(); j++) begin
            checkOutput($sformatf("b2b spacing[%0d]", j), 128'(acceptCyc[j] - acceptCyc[j-1]), 128'(BN + 2));
        end
        cnt = 0;
        while (expUq.size() > 0 && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        checkOutput("b2b all results drained", 128'(expUq.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
